// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, Rcon table,
// key-expansion FSM state encoding and the 128-bit key type.
package aes_pkg;

    localparam int AES_128_N_ROUND = 10;

    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_e;

    // Round constant for round r (1..10); only the MSB byte of the word is non-zero.
    function automatic logic [7:0] aes_rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel forward AES S-box lookups on a 32-bit word.
// Purely combinational.
module aes_sbox_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise substitution, byte order preserved.
    always_comb begin
        word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                    SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion into an 11-entry round-key store, one round per cycle.
// A rising edge on key_valid (seen low at least once since reset) starts a
// new expansion; round keys are read combinationally by rd_round.
// Optional macro AES_KEY_RANGE_CHECK_EN: out-of-range rd_round reads return
// zero and raise rd_err; otherwise they alias round 10 and rd_err stays 0.
// dbg_state exposes the FSM state for checkers.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter bit CLR_ON_START = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    input  logic [3:0]   rd_round,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_ready,
    output logic         busy,
    output logic         rd_err,
    output aes_state_e   dbg_state
);

    aes_state_e state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       kv_q, kv_d;
    logic       armed_q, armed_d;
    aes_key_t   store_q [0:AES_128_N_ROUND];
    aes_key_t   store_d [0:AES_128_N_ROUND];

    aes_key_t    prev_key;
    aes_key_t    next_key;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] w0n, w1n, w2n, w3n;
    logic        start_edge;

    // armed_q blocks a key_valid that was already high when reset released.
    assign start_edge = key_valid & ~kv_q & armed_q;

    // Select the previous round key and form RotWord of its last word.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < AES_128_N_ROUND; i++) begin
            if (rcnt_q == 4'(i + 1)) prev_key = store_q[i];
        end
        rot_word = {prev_key[23:0], prev_key[31:24]};
    end

    aes_sbox_word u_sbox (
        .word_in  (rot_word),
        .word_out (sub_word)
    );

    // FIPS-197 word recurrence for round rcnt_q.
    always_comb begin
        w0n      = prev_key[127:96] ^ sub_word ^ {aes_rcon(rcnt_q), 24'h0};
        w1n      = prev_key[95:64] ^ w0n;
        w2n      = prev_key[63:32] ^ w1n;
        w3n      = prev_key[31:0]  ^ w2n;
        next_key = {w0n, w1n, w2n, w3n};
    end

    // Next-state logic for the FSM, round counter, flags and key store.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        kv_d    = key_valid;
        armed_d = armed_q | ~key_valid;
        store_d = store_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_LOAD: begin
                store_d[0] = key_in;
                if (CLR_ON_START) begin
                    for (int i = 1; i <= AES_128_N_ROUND; i++) store_d[i] = '0;
                end
                rcnt_d  = 4'd1;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                for (int i = 1; i <= AES_128_N_ROUND; i++) begin
                    if (rcnt_q == 4'(i)) store_d[i] = next_key;
                end
                if (rcnt_q == 4'(AES_128_N_ROUND)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            kv_q    <= 1'b0;
            armed_q <= 1'b0;
            store_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            kv_q    <= kv_d;
            armed_q <= armed_d;
            store_q <= store_d;
        end
    end

    // Combinational round-key read port with out-of-range handling.
    always_comb begin
        rd_err    = 1'b0;
        round_key = store_q[AES_128_N_ROUND];
        for (int i = 0; i <= AES_128_N_ROUND; i++) begin
            if (rd_round == 4'(i)) round_key = store_q[i];
        end
`ifdef AES_KEY_RANGE_CHECK_EN
        if (rd_round > 4'(AES_128_N_ROUND)) begin
            round_key = '0;
            rd_err    = rst;   // held low while reset is asserted
        end
`endif
    end

    assign round_num = 4'(AES_128_N_ROUND);
    assign key_ready = ready_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed testbench for aes_key_expand: FIPS-197 schedule table, start
// timing, ignored restart, mid-expansion reset, back-to-back keys.
module tb_aes_key_expand;
    import aes_pkg::*;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic [3:0]   rd_round = '0;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_ready;
    logic         busy;
    logic         rd_err;
    aes_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [3:0]   rd;
        logic [127:0] exp;
    } vec_t;
    vec_t fips_tbl[11];

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .rd_round  (rd_round),
        .round_key (round_key),
        .round_num (round_num),
        .key_ready (key_ready),
        .busy      (busy),
        .rd_err    (rd_err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_sb(input string name, input logic [127:0] act);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // Present a key and create a fresh rising edge on key_valid.
    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b1;
    endtask

    task automatic wait_ready(input string name, input int bound);
        int c = 0;
        while (key_ready !== 1'b1 && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, 128'(key_ready), 128'd1);
    endtask

    task automatic read_key(input string name, input logic [3:0] rd, input logic [127:0] exp);
        rd_round = rd;
        exp_q.push_back(exp);
        #1;
        check_sb(name, round_key);
    endtask

    initial begin
        fips_tbl[0]  = '{4'd0,  KEY_FIPS};
        fips_tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        fips_tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        fips_tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fips_tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fips_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fips_tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fips_tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fips_tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        fips_tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        fips_tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        // Reset state, key_valid held high through reset.
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        #12;
        check("rst_round_key", round_key, 128'h0);
        check("rst_key_ready", 128'(key_ready), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rd_err", 128'(rd_err), 128'd0);
        check("rst_round_num", 128'(round_num), 128'd10);
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("held_kv_no_start_ready", 128'(key_ready), 128'd0);
        check("held_kv_no_start_busy", 128'(busy), 128'd0);

        // FIPS key: start timing.
        start_key(KEY_FIPS);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                check("fips_busy_after_edge", 128'(busy), 128'd1);
                check("fips_ready_after_edge", 128'(key_ready), 128'd0);
            end
            if (i == 11) check("fips_ready_cycle11", 128'(key_ready), 128'd0);
            if (i == 12) begin
                check("fips_ready_cycle12", 128'(key_ready), 128'd1);
                check("fips_busy_cycle12", 128'(busy), 128'd0);
            end
        end
        @(negedge clk);
        key_valid = 1'b0;

        // Round-key table, read combinationally without clock edges.
        for (int i = 0; i < 11; i++) begin
            read_key($sformatf("fips_round_%0d", i), fips_tbl[i].rd, fips_tbl[i].exp);
        end

        // Out-of-range read.
        rd_round = 4'd12;
        #1;
`ifdef AES_KEY_RANGE_CHECK_EN
        check("oor_round_key", round_key, 128'h0);
        check("oor_rd_err", 128'(rd_err), 128'd1);
`else
        check("oor_round_key", round_key, fips_tbl[10].exp);
        check("oor_rd_err", 128'(rd_err), 128'd0);
`endif

        // Back-to-back: zero key right after a finished expansion.
        start_key(KEY_ZERO);
        @(posedge clk);
        #1;
        check("b2b_ready_drop", 128'(key_ready), 128'd0);
        wait_ready("b2b_ready", 20);
        read_key("zero_round_1", 4'd1, 128'h62636363626363636263636362636363);
        read_key("zero_round_2", 4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        read_key("zero_round_10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Restart edge and key change during EXPAND must be ignored.
        start_key(KEY_SEQ);
        repeat (6) @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = KEY_FIPS;
        @(negedge clk);
        key_valid = 1'b1;
        wait_ready("ign_ready", 20);
        read_key("ign_round_0", 4'd0, KEY_SEQ);
        read_key("ign_round_1", 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read_key("ign_round_10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_restart_state", 128'(dbg_state), 128'(ST_IDLE));

        // Reset in the middle of EXPAND.
        start_key(KEY_FIPS);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_ready", 128'(key_ready), 128'd0);
        check("midrst_state", 128'(dbg_state), 128'(ST_IDLE));
        rd_round = 4'd0;
        #1;
        check("midrst_round0", round_key, 128'h0);
        rd_round = 4'd1;
        #1;
        check("midrst_round1", round_key, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_restart_ready", 128'(key_ready), 128'd0);
        check("midrst_no_restart_busy", 128'(busy), 128'd0);

        // A fresh start after reset works again.
        start_key(KEY_ZERO);
        wait_ready("post_rst_ready", 20);
        read_key("post_rst_round_10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
